// File: rtl/uart_line_editor.sv
// Line editor between a UART receiver and transmitter: collects one line with
// case swap and backspace editing, then replays it on an AXI-Stream style port.
module uart_line_editor #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       sresetn,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       m_axis_tready,
  output logic       m_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tlast,
  output logic       m_axis_ttrunc,
  output logic       drop,
  output logic       dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_EMIT    = 1'b1;
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

  // Stream handshake: a byte transfers on a rising edge where m_axis_tvalid and
  // m_axis_tready are both 1; tvalid/tdata/tlast/ttrunc hold until that edge.

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          trunc_q, trunc_d;
  logic          tvalid_q, tvalid_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          tlast_q, tlast_d;
  logic          ttrunc_q, ttrunc_d;
  logic          drop_q, drop_d;

  logic [7:0]    mem [DEPTH];
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_next;

  logic       is_bs, is_term, is_alpha;
  logic [7:0] conv_byte;

  always_comb begin
    is_bs     = (s_data == 8'h08) || (s_data == 8'h7F);
    is_term   = (s_data == 8'h0A) || (s_data == 8'h0D);
    is_alpha  = ((s_data >= 8'h41) && (s_data <= 8'h5A)) ||
                ((s_data >= 8'h61) && (s_data <= 8'h7A));
    conv_byte = is_alpha ? (s_data ^ 8'h20) : s_data;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    trunc_d  = trunc_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    ttrunc_d = ttrunc_q;
    drop_d   = 1'b0;
    wr_en    = 1'b0;
    wr_data  = conv_byte;
    rd_next  = rd_ptr_q + AW'(1);

    case (state_q)
      ST_COLLECT: begin
        if (s_valid) begin
          if (is_bs) begin
            if (count_q != '0) count_d = count_q - AW'(1);
          end else if (is_term) begin
            if (count_q != '0) begin
              // Slot 0 already holds the first character, so the first byte
              // can be presented on the very next cycle.
              wr_en    = 1'b1;
              wr_data  = s_data;
              state_d  = ST_EMIT;
              rd_ptr_d = '0;
              tvalid_d = 1'b1;
              tdata_d  = mem[0];
              tlast_d  = 1'b0;
              ttrunc_d = trunc_q;
            end
          end else if (count_q == LAST_SLOT) begin
            drop_d  = 1'b1;
            trunc_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + AW'(1);
          end
        end
      end
      default: begin
        drop_d = s_valid;
        if (m_axis_tready) begin
          if (tlast_q) begin
            state_d  = ST_COLLECT;
            count_d  = '0;
            rd_ptr_d = '0;
            trunc_d  = 1'b0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            ttrunc_d = 1'b0;
          end else begin
            // count_q still indexes the stored terminator during replay.
            rd_ptr_d = rd_next;
            tdata_d  = mem[rd_next];
            tlast_d  = (rd_next == count_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q  <= ST_COLLECT;
      count_q  <= '0;
      rd_ptr_q <= '0;
      trunc_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= 8'h00;
      tlast_q  <= 1'b0;
      ttrunc_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      trunc_q  <= trunc_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      ttrunc_q <= ttrunc_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q] <= wr_data;
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_ttrunc = ttrunc_q;
  assign drop          = drop_q;
  assign dbg_state     = state_q[0];

endmodule

// File: doc/uart_line_editor.md
UART_LINE_EDITOR -- requirements
Module: uart_line_editor

Interface
REQ-001 Parameter DEPTH, default 64, line buffer entries incl. terminator; legal range 2..1024.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 sresetn  input  1  asynchronous active-low reset; assertion clears state immediately, deassertion is synchronised by the system reset generator.
REQ-004 s_valid  input  1  one-cycle strobe: s_data holds a received byte; no backpressure.
REQ-005 s_data  input  8  received byte, sampled only when s_valid=1.
REQ-006 m_axis_tready  input  1  downstream (UART TX path) ready.
REQ-007 m_axis_tvalid  output  1  output byte valid.
REQ-008 m_axis_tdata  output  8  output byte.
REQ-009 m_axis_tlast  output  1  high on the terminator byte of each line.
REQ-010 m_axis_ttrunc  output  1  high with every byte of a line that lost characters to overflow.
REQ-011 drop  output  1  one-cycle pulse: an input byte was discarded (overflow or arrival during EMIT).

Function
REQ-012 Two states: COLLECT (accepts input, tvalid=0) and EMIT (outputs buffered line, ignores input).
REQ-013 COLLECT, s_valid with s_data in 0x41..0x5A or 0x61..0x7A: store s_data XOR 0x20 at index count, count+1.
REQ-014 COLLECT, other non-control byte (not 0x08, 0x7F, 0x0A, 0x0D): store unchanged, count+1.
REQ-015 Text capacity DEPTH-1 characters; storable byte when count=DEPTH-1: not stored, drop pulses next cycle, line truncated flag set.
REQ-016 Backspace 0x08 or 0x7F: count-1 if count>0, else ignored; never stored; never clears truncated flag.
REQ-017 Terminator 0x0A or 0x0D with count=0: discarded silently (no drop pulse); state stays COLLECT (CR LF pair yields one line).
REQ-018 Terminator with count>0: stored at index count (slot always free), length=count+1, transition to EMIT next cycle.
REQ-019 EMIT: m_axis_tvalid rises the cycle after the terminator is sampled; bytes presented index 0..length-1 in order.
REQ-020 tdata, tlast, ttrunc registered; held stable while tvalid=1 and tready=0; no bubbles while tready=1 (one byte per cycle).
REQ-021 tlast=1 exactly on index length-1; ttrunc constant for the whole line.
REQ-022 Handshake on tlast byte: next cycle tvalid=0, count=0, truncated flag cleared, state COLLECT.
REQ-023 s_valid during EMIT, including the cycle of the final handshake: byte discarded, drop pulses next cycle.
REQ-024 tvalid never deasserts before its handshake; tready ignored in COLLECT.
REQ-025 Buffer: single-port-per-side RAM of DEPTH x 8, write pointer = count, read pointer separate counter; pointers log2(DEPTH) bits, no wrap (reset to 0 per line).

Reset
REQ-026 While sresetn=0: state COLLECT, count=0, read pointer=0, truncated flag=0, m_axis_tvalid=0, m_axis_tdata=0x00, m_axis_tlast=0, m_axis_ttrunc=0, drop=0.
REQ-027 Reset mid-EMIT or mid-COLLECT discards the partial line; buffer contents need no reset and are never output without a new line.
REQ-028 First s_valid honoured is the first sampled edge after sresetn deassertion.

Verification
REQ-029 Bytes "aB1" then 0x0D, tready=1 -> output 0x41,0x62,0x31,0x0D, tlast only on 0x0D, ttrunc=0, first tvalid one cycle after 0x0D.
REQ-030 "ab", 0x08, "c", 0x0A -> output 0x41,0x43,0x0A; then 0x0A alone -> no output.
REQ-031 DEPTH=4, "abcdef", 0x0D -> output 0x41,0x42,0x43,0x0D with ttrunc=1, three drop pulses.
REQ-032 "xy" 0x0D with tready toggled 1,0,0,1,... -> each byte held stable across stall cycles, sequence 0x58,0x59,0x0D unchanged.
REQ-033 Send "z" during EMIT of a prior line -> drop pulses, "z" never output; next line emitted correctly.
REQ-034 sresetn asserted during EMIT with tvalid=1 -> tvalid=0 asynchronously, all outputs at reset values; following "q" 0x0D emits 0x51,0x0D.
